// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : Issue/result bundle between decode stage and the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, in1, in2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, funct, in1, in2,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [5:0]       c_MULT     = 6'b011000;
  localparam logic [5:0]       c_MULTU    = 6'b011001;
  localparam logic [5:0]       c_DIV      = 6'b011010;
  localparam logic [5:0]       c_DIVU     = 6'b011011;
  localparam logic [5:0]       c_MTHI     = 6'b010001;
  localparam logic [5:0]       c_MTLO     = 6'b010011;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0]   mq_q, mq_d;       // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0]   op_q, op_d;       // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand decode at issue
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  // Per-step datapath
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_rs;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_is_mul = (bus.funct == c_MULT) || (bus.funct == c_MULTU);
  assign w_is_div = (bus.funct == c_DIV)  || (bus.funct == c_DIVU);
  assign w_signed = (bus.funct == c_MULT) || (bus.funct == c_DIV);
  assign w_a_neg  = w_signed & bus.in1[WIDTH-1];
  assign w_b_neg  = w_signed & bus.in2[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~bus.in1 + 1'b1) : bus.in1;
  assign w_b_mag  = w_b_neg ? (~bus.in2 + 1'b1) : bus.in2;

  assign w_mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
  assign w_div_rs   = {acc_q, mq_q[WIDTH-1]};
  assign w_div_ge   = (w_div_rs >= {1'b0, op_q});
  // Only used when rs >= divisor, so the difference always fits in WIDTH bits
  assign w_div_diff = w_div_rs[WIDTH-1:0] - op_q;
  assign w_prod_mag = {acc_q, mq_q};
  assign w_prod_neg = ~w_prod_mag + 1'b1;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    op_d      = op_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (w_is_mul || w_is_div) begin
            state_d   = S_RUN;
            count_d   = '0;
            acc_d     = '0;
            is_div_d  = w_is_div;
            neg_d     = w_a_neg ^ w_b_neg;
            rem_neg_d = w_a_neg;
            dz_d      = w_is_div && (bus.in2 == '0);
            mq_d      = w_is_div ? w_a_mag : w_b_mag;
            op_d      = w_is_div ? w_b_mag : w_a_mag;
          end else if (bus.funct == c_MTHI) begin
            hi_d = bus.in1;
          end else if (bus.funct == c_MTLO) begin
            lo_d = bus.in1;
          end
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_d = w_div_ge ? w_div_diff : w_div_rs[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], w_div_ge};
        end else begin
          acc_d = w_mul_sum[WIDTH:1];
          mq_d  = {w_mul_sum[0], mq_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == c_CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // Zero divisor: remainder path already yields in1; quotient forced all-ones
          lo_d = dz_q ? {WIDTH{1'b1}} : (neg_q ? (~mq_q + 1'b1) : mq_q);
          hi_d = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? w_prod_neg : w_prod_mag;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      op_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      op_q      <= op_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
`default_nettype wire
